// File: rtl/controller_bank.sv
// controller_bank: N-channel button front end.
// Synchronize, debounce, press/repeat pulses and LED stretch per channel.
module controller_bank #(
    parameter int             N               = 12,
    parameter int             DEBOUNCE_CYCLES = 500000,
    parameter int             REPEAT_DELAY    = 25000000,
    parameter int             REPEAT_RATE     = 5000000,
    parameter int             LED_CYCLES      = 12500000,
    parameter logic [N-1:0]   REPEAT_MASK     = {N{1'b0}},
    parameter bit             ACTIVE_LOW      = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         block,
    input  logic [N-1:0] btn_in,
    output logic [N-1:0] btn_pulse,
    output logic [N-1:0] btn_level,
    output logic [N-1:0] led_out
);

    localparam int MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ?
                           DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_B = (REPEAT_RATE > LED_CYCLES) ?
                           REPEAT_RATE : LED_CYCLES;
    localparam int MAX_V = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_V + 1);

    localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] RD_LAST  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RR_LAST  = CW'(REPEAT_RATE - 1);
    localparam logic [CW-1:0] LED_LOAD = CW'(LED_CYCLES);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_DELAY,
        S_REPEAT,
        S_HELD,
        S_WAIT_REL
    } state_t;

    for (genvar gi = 0; gi < N; gi++) begin : g_ch
        logic          w_raw;
        logic          r_sync1;
        logic          r_sync2;
        logic          r_level;
        logic [CW-1:0] r_db_cnt;
        state_t        r_state;
        state_t        w_state_nxt;
        logic [CW-1:0] r_tmr;
        logic [CW-1:0] w_tmr_nxt;
        logic          r_pulse;
        logic          w_pulse_nxt;
        logic [CW-1:0] r_led_cnt;

        assign w_raw = btn_in[gi] ^ ACTIVE_LOW;

        // Two-flop synchronizer on the (optionally inverted) raw pin.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
            end else begin
                r_sync1 <= w_raw;
                r_sync2 <= r_sync1;
            end
        end

        // Accept a level change only after it has been stable long enough.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_db_cnt <= '0;
                r_level  <= 1'b0;
            end else if (r_sync2 == r_level) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_db_cnt <= '0;
                r_level  <= ~r_level;
            end else if (r_db_cnt != CNT_MAX) begin
                r_db_cnt <= r_db_cnt + CW'(1);
            end
        end

        // Press/repeat FSM state, timer and registered pulse.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_state <= S_IDLE;
                r_tmr   <= '0;
                r_pulse <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_tmr   <= w_tmr_nxt;
                r_pulse <= w_pulse_nxt;
            end
        end

        // Next state; a due pulse waits one cycle if the last one is still high.
        always_comb begin
            w_state_nxt = r_state;
            w_tmr_nxt   = r_tmr;
            w_pulse_nxt = 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    w_tmr_nxt = '0;
                    if (r_level) begin
                        if (block) begin
                            w_state_nxt = S_WAIT_REL;
                        end else begin
                            w_pulse_nxt = 1'b1;
                            w_state_nxt = REPEAT_MASK[gi] ? S_DELAY : S_HELD;
                        end
                    end
                end
                S_DELAY, S_REPEAT: begin
                    if (!r_level) begin
                        w_state_nxt = S_IDLE;
                        w_tmr_nxt   = '0;
                    end else if (block) begin
                        w_state_nxt = S_WAIT_REL;
                        w_tmr_nxt   = '0;
                    end else if (r_tmr == ((r_state == S_DELAY) ?
                                           RD_LAST : RR_LAST)) begin
                        if (!r_pulse) begin
                            w_pulse_nxt = 1'b1;
                            w_tmr_nxt   = '0;
                            w_state_nxt = S_REPEAT;
                        end
                    end else if (r_tmr != CNT_MAX) begin
                        w_tmr_nxt = r_tmr + CW'(1);
                    end
                end
                S_HELD: begin
                    if (!r_level) begin
                        w_state_nxt = S_IDLE;
                    end else if (block) begin
                        w_state_nxt = S_WAIT_REL;
                    end
                end
                S_WAIT_REL: begin
                    if (!r_level) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_tmr_nxt   = '0;
                end
            endcase
        end

        // Retriggerable LED stretcher: each pulse reloads the full on-time.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_led_cnt <= '0;
            end else if (r_pulse) begin
                r_led_cnt <= LED_LOAD;
            end else if (r_led_cnt != '0) begin
                r_led_cnt <= r_led_cnt - CW'(1);
            end
        end

        assign btn_pulse[gi] = r_pulse;
        assign btn_level[gi] = r_level;
        assign led_out[gi]   = (r_led_cnt != '0);
    end

endmodule

// File: doc/controller_bank.md
# controller_bank

Parametrised successor to the 12-button front-panel input controller: N independent channels, each with a 2-flop synchronizer, a counter-based debouncer, single-cycle press pulses, optional hold-to-repeat, and a retriggerable LED stretcher. It sits between the raw push-button/controller pins and the game FSM. A `block` input suppresses all press events. After `block` drops, a new event needs a fresh press.

## Interface
- `N`, 12, number of channels.
- `DEBOUNCE_CYCLES`, 500000, consecutive stable cycles needed to accept a level change (≥2).
- `REPEAT_DELAY`, 25000000, held cycles from the initial press pulse to the first repeat pulse (≥1).
- `REPEAT_RATE`, 5000000, cycles between subsequent repeat pulses (≥1).
- `LED_CYCLES`, 12500000, LED on-time after each pulse (≥1).
- `REPEAT_MASK`, {N{1'b0}}, per-channel repeat enable; bit i = 1 enables repeat on channel i.
- `ACTIVE_LOW`, 0, 1 inverts all raw inputs before synchronization.
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `block`  in  1  synchronous; 1 suppresses all pulses.
- `btn_in`  in  N  raw asynchronous button levels.
- `btn_pulse`  out  N  one-cycle press/repeat event per channel.
- `btn_level`  out  N  debounced held level per channel.
- `led_out`  out  N  stretched pulse indicator per channel.

## Operation
- Each channel is identical and independent. Channels share no counters.
- Synchronizer: two flops per channel, reset to 0 (the released state after optional inversion).
- Debouncer:
  - `cnt` counts cycles where synced ≠ `btn_level`. Any cycle where they are equal clears `cnt` to 0.
  - When `cnt` = DEBOUNCE_CYCLES−1 and synced still differs, `btn_level` toggles on that edge and `cnt` clears.
  - Counter width is $clog2(max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE, LED_CYCLES)+1).
  - Counters saturate and never wrap.
- Per-channel FSM:
  - IDLE: on the rising edge of `btn_level`, if `block`=0, emit a pulse. Then go to DELAY if REPEAT_MASK[i]=1, else to HELD. If `block`=1, go to WAIT_REL with no pulse.
  - DELAY: timer counts from 0. At REPEAT_DELAY−1, emit a pulse, clear the timer and go to REPEAT.
  - REPEAT: at REPEAT_RATE−1, emit a pulse and clear the timer; stay in REPEAT.
  - HELD: wait for release.
  - WAIT_REL: wait for release; no pulses.
  - Falling `btn_level` in any state → IDLE with no pulse.
  - `block`=1 in DELAY, REPEAT or HELD → WAIT_REL in the same cycle, and that cycle's pulse is suppressed.
- `btn_pulse[i]` is registered and high for exactly one cycle per event. It is never high in two consecutive cycles, even with REPEAT_RATE=1.
  - With REPEAT_RATE=1 the effective rate is every 2 cycles.
- LED: each `btn_pulse[i]` reloads a down-counter to LED_CYCLES. `led_out[i]` = (counter ≠ 0). A retrigger while lit extends the on-time from the new pulse.
- Reset mid-operation: all FSMs go to IDLE, and counters, `btn_level`, `btn_pulse` and `led_out` go to 0 immediately. A button still held at reset release is accepted as a new press after debounce.

## Timing
- Reset values: `btn_pulse`=0, `btn_level`=0, `led_out`=0, all FSMs in IDLE.
- Press latency: a raw input that changes and stays stable is seen at the synchronizer output after 2 edges. `btn_level` rises DEBOUNCE_CYCLES edges later. `btn_pulse` is high in the cycle after `btn_level` rises.
- Total latency from raw edge to pulse: DEBOUNCE_CYCLES+3 cycles.
- Release latency: `btn_level` falls DEBOUNCE_CYCLES+2 cycles after a stable raw release.
- First repeat pulse: REPEAT_DELAY cycles after the initial pulse. Later repeats: every REPEAT_RATE cycles.
- `led_out` rises in the cycle after `btn_pulse`. It stays high for exactly LED_CYCLES cycles after the last pulse.
- `block` is sampled each edge. It takes effect on a pulse in the same cycle the FSM would emit it.

## Test plan
Parameters for all scenarios: N=4, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, LED_CYCLES=5, REPEAT_MASK=4'b0010.
- Clean press on ch0, held 30 cycles → exactly one `btn_pulse[0]`, 7 cycles after the raw edge. `btn_level[0]` is high until 6 cycles after release. `led_out[0]` is high for 5 cycles.
- Bounce on ch0: raw toggles every 2 cycles for 20 cycles, then stays high → no pulse during the bounce. One pulse 7 cycles after the final edge.
- Repeat on ch1, held 30 cycles past the first pulse → pulses at offsets 0, 10, 13, 16, …, 28 from the first pulse. No pulse on release. `led_out[1]` stays continuously high during repeats.
- `block`=1 asserted at repeat offset 11 on ch1, then dropped while ch1 is still held → no further pulses until ch1 is released and pressed again. The fresh press then gives one pulse.
- Simultaneous press on ch0 and ch3 → pulses in the same cycle on both. Each channel's LED is independent.
- Assert `reset` while ch1 is in REPEAT with its LED lit → all outputs are 0 immediately. With the button still held after reset release, one pulse follows 7 cycles later.
